// File: rtl/boxcar_decimator.sv
// Signed boxcar accumulate-and-decimate: sums N valid samples, rounds and shifts the block
// sum, then saturates to OWIDTH with a sticky overflow flag. No back-pressure.
module boxcar_decimator #(
    parameter int IWIDTH    = 16,
    parameter int OWIDTH    = 16,
    parameter int LOG2_MAXN = 10,
    parameter int SHIFTW    = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inValid,
    input  logic [IWIDTH-1:0]    inData,
    input  logic [LOG2_MAXN-1:0] decimation,
    input  logic [SHIFTW-1:0]    shift,
    input  logic                 resync,
    input  logic                 clearOverflow,
    output logic                 outValid,
    output logic [OWIDTH-1:0]    outData,
    output logic                 overflow
);
    // Handshake: inValid qualifies inData for one cycle and is always accepted;
    // outValid is a single-cycle strobe and outData holds until the next strobe.

    localparam int AWIDTH = IWIDTH + LOG2_MAXN;
    localparam int RWIDTH = AWIDTH + 1;
    localparam int SMAX   = AWIDTH - 1;
    localparam logic signed [RWIDTH-1:0] OMAX = {{(RWIDTH-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
    localparam logic signed [RWIDTH-1:0] OMIN = {{(RWIDTH-OWIDTH+1){1'b1}}, {(OWIDTH-1){1'b0}}};

    // stage 0: accumulate
    logic signed [AWIDTH-1:0] acc;
    logic [LOG2_MAXN-1:0]     count;
    logic [LOG2_MAXN-1:0]     dec_lat;
    logic [SHIFTW-1:0]        shift_lat;
    logic signed [AWIDTH-1:0] sum;
    logic [SHIFTW-1:0]        sum_shift;
    logic                     sum_valid;

    logic signed [AWIDTH-1:0] base_acc;
    logic signed [AWIDTH-1:0] acc_sum;
    logic [LOG2_MAXN-1:0]     base_count;
    logic [LOG2_MAXN-1:0]     eff_dec;
    logic [SHIFTW-1:0]        eff_shift;
    logic                     first;

    // resync makes the current sample (if any) the first of a fresh block
    always_comb begin
        base_count = resync ? '0 : count;
        base_acc   = resync ? '0 : acc;
        first      = (base_count == '0);
        eff_dec    = first ? decimation : dec_lat;
        eff_shift  = first ? shift : shift_lat;
        acc_sum    = base_acc + {{LOG2_MAXN{inData[IWIDTH-1]}}, inData};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            count     <= '0;
            dec_lat   <= '0;
            shift_lat <= '0;
            sum       <= '0;
            sum_shift <= '0;
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            if (inValid) begin
                if (first) begin
                    dec_lat   <= decimation;
                    shift_lat <= shift;
                end
                if (base_count == eff_dec) begin
                    sum       <= acc_sum;
                    sum_shift <= eff_shift;
                    sum_valid <= 1'b1;
                    acc       <= '0;
                    count     <= '0;
                end else begin
                    acc   <= acc_sum;
                    count <= base_count + LOG2_MAXN'(1);
                end
            end else if (resync) begin
                acc   <= '0;
                count <= '0;
            end
        end
    end

    // stage 1: round half up, arithmetic shift, one guard bit
    int                       s_amt;
    logic signed [RWIDTH-1:0] sum_ext;
    logic signed [RWIDTH-1:0] rnd;
    logic signed [RWIDTH-1:0] rnd_sum;
    logic signed [RWIDTH-1:0] r_comb;
    logic signed [RWIDTH-1:0] r;
    logic                     r_valid;

    always_comb begin
        s_amt   = (int'(sum_shift) > SMAX) ? SMAX : int'(sum_shift);
        sum_ext = {sum[AWIDTH-1], sum};
        rnd     = '0;
        if (s_amt != 0) begin
            rnd = RWIDTH'(1) << (s_amt - 1);
        end
        rnd_sum = sum_ext + rnd;
        r_comb  = rnd_sum >>> s_amt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r       <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= sum_valid;
            if (sum_valid) begin
                r <= r_comb;
            end
        end
    end

    // stage 2: clamp to OWIDTH, keeping the sign
    logic [OWIDTH-1:0] sat_comb;
    logic              ovf_comb;
    logic [OWIDTH-1:0] sat_data;
    logic              sat_ovf;
    logic              sat_valid;

    always_comb begin
        sat_comb = r[OWIDTH-1:0];
        ovf_comb = 1'b0;
        if (r > OMAX) begin
            sat_comb = OMAX[OWIDTH-1:0];
            ovf_comb = 1'b1;
        end else if (r < OMIN) begin
            sat_comb = OMIN[OWIDTH-1:0];
            ovf_comb = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_data  <= '0;
            sat_ovf   <= 1'b0;
            sat_valid <= 1'b0;
        end else begin
            sat_valid <= r_valid;
            if (r_valid) begin
                sat_data <= sat_comb;
                sat_ovf  <= ovf_comb;
            end
        end
    end

    // output register; a saturation event wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid <= 1'b0;
            outData  <= '0;
            overflow <= 1'b0;
        end else begin
            outValid <= sat_valid;
            if (sat_valid) begin
                outData <= sat_data;
            end
            if (sat_valid && sat_ovf) begin
                overflow <= 1'b1;
            end else if (clearOverflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_boxcar_decimator.sv
// Directed bench for boxcar_decimator: a driver pushes hand-computed results and their
// due cycle into a queue; an independent monitor pops and compares on each outValid.
module tb_boxcar_decimator;
    localparam int IW = 16;
    localparam int OW = 16;
    localparam int LM = 10;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          inValid = 1'b0;
    logic [IW-1:0] inData = '0;
    logic [LM-1:0] decimation = '0;
    logic [SW-1:0] shift = '0;
    logic          resync = 1'b0;
    logic          clearOverflow = 1'b0;
    logic          outValid;
    logic [OW-1:0] outData;
    logic          overflow;

    logic [OW-1:0] exp_q[$];
    int            cyc_q[$];
    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;
    logic [OW-1:0] mon_exp;
    int            mon_cyc;

    boxcar_decimator #(.IWIDTH(IW), .OWIDTH(OW), .LOG2_MAXN(LM), .SHIFTW(SW)) dut (
        .clk(clk), .rst_n(rst_n), .inValid(inValid), .inData(inData),
        .decimation(decimation), .shift(shift), .resync(resync),
        .clearOverflow(clearOverflow), .outValid(outValid), .outData(outData),
        .overflow(overflow)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int d);
        inValid = 1'b1;
        inData  = IW'(d);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        resync  = 1'b0;
    endtask

    task automatic send_end(input int d, input int e);
        send(d);
        exp_q.push_back(OW'(e));
        cyc_q.push_back(cyc + 3);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        exp_q.delete();
        cyc_q.delete();
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && outValid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0d expected none", $signed(outData));
            end else begin
                mon_exp = exp_q.pop_front();
                mon_cyc = cyc_q.pop_front();
                check("out_data", $signed(outData), $signed(mon_exp));
                check("out_latency_cycle", cyc, mon_cyc);
            end
        end
    end

    initial begin
        idle(3);
        check("reset_outValid", int'(outValid), 0);
        check("reset_outData", $signed(outData), 0);
        check("reset_overflow", int'(overflow), 0);
        rst_n = 1'b1;
        idle(1);

        // T1 / T2: rounding of positive and negative sums
        decimation = 10'd3;
        shift = 5'd2;
        send(1); send(2); send(3); send_end(4, 3);
        wait_drain();
        check("t1_overflow", int'(overflow), 0);
        send(-1); send(-2); send(-3); send_end(-4, -2);
        wait_drain();

        // T3: saturation and sticky overflow
        shift = 5'd0;
        repeat (3) send(32767);
        send_end(32767, 32767);
        wait_drain();
        check("t3_ovf_pos", int'(overflow), 1);
        repeat (3) send(-32768);
        send_end(-32768, -32768);
        wait_drain();
        check("t3_ovf_neg", int'(overflow), 1);
        clearOverflow = 1'b1;
        idle(1);
        clearOverflow = 1'b0;
        check("t3_ovf_cleared", int'(overflow), 0);
        repeat (3) send(32767);
        send_end(32767, 32767);
        idle(2);
        clearOverflow = 1'b1;
        idle(1);
        clearOverflow = 1'b0;
        check("t3_set_beats_clear", int'(overflow), 1);
        wait_drain();
        clearOverflow = 1'b1;
        idle(1);
        clearOverflow = 1'b0;
        check("t3_ovf_cleared2", int'(overflow), 0);
        idle(3);
        check("hold_outValid", int'(outValid), 0);
        check("hold_outData", $signed(outData), 32767);

        // T4: gaps, and a mid-block decimation change applies to the next block
        decimation = 10'd2;
        send(1); idle(1); send(1);
        decimation = 10'd1;
        idle(2);
        send_end(1, 3);
        send(4); send_end(6, 10);
        wait_drain();

        // T5: resync with a sample starts a new block
        decimation = 10'd3;
        send(5); send(5);
        resync = 1'b1;
        send(7);
        send(1); send(1); send_end(1, 10);
        wait_drain();

        // N=1 back-to-back, rounding, shift clamp, resync with N=1
        decimation = 10'd0;
        shift = 5'd1;
        send_end(3, 2); send_end(-3, -1); send_end(0, 0);
        shift = 5'd31;
        send_end(5, 0); send_end(-5, 0);
        shift = 5'd0;
        resync = 1'b1;
        send_end(9, 9);
        wait_drain();

        // N=1024, full accumulator range
        decimation = 10'd1023;
        shift = 5'd10;
        repeat (1023) send(-32768);
        send_end(-32768, -32768);
        wait_drain();
        check("maxn_overflow", int'(overflow), 0);

        // leave overflow set and outData nonzero before the reset tests
        decimation = 10'd1;
        shift = 5'd0;
        send(32767); send_end(32767, 32767);
        wait_drain();
        check("pre_t6_overflow", int'(overflow), 1);

        // T6: reset mid-block, then reset with a sum in stage 1
        decimation = 10'd3;
        send(2); send(2);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        repeat (4) send(3);
        rst_n = 1'b0;
        idle(2);
        check("t6_rst_outValid", int'(outValid), 0);
        check("t6_rst_outData", $signed(outData), 0);
        check("t6_rst_overflow", int'(overflow), 0);
        rst_n = 1'b1;
        idle(6);
        check("t6_post_outValid", int'(outValid), 0);
        check("t6_post_outData", $signed(outData), 0);
        send(2); send(2); send(2); send_end(2, 8);
        wait_drain();
        check("t6_final_overflow", int'(overflow), 0);

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
